// File: rtl/dffre_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dffre_reg                                                    |
// | Brief    : WIDTH-bit register, sync active-low reset, optional enable.  |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module dffre_reg #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter bit              USE_EN      = 1'b1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH < 1 || WIDTH > 1024) begin : g_width_check
            $error("dffre_reg: WIDTH=%0d outside legal range 1..1024", WIDTH);
        end
    endgenerate

    // Declaration initialiser gives the pre-reset value in simulation only.
    logic [WIDTH-1:0] q_q = RESET_VALUE;
    logic [WIDTH-1:0] q_d;

    generate
        if (USE_EN) begin : g_en
            // An unknown enable must poison q rather than quietly hold it.
            always_comb begin
                q_d = q_q;
                case (en)
                    1'b1:    q_d = d;
                    1'b0:    q_d = q_q;
                    default: q_d = {WIDTH{1'bx}};
                endcase
            end
        end else begin : g_no_en
            logic unused_en;
            assign unused_en = en;
            assign q_d       = d;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!r) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: tb/tb_dffre_reg.sv
`default_nettype none
// Bench for dffre_reg: several parameterisations driven by directed vectors,
// expected values queued by the driver and retired by a negedge monitor.
module tb_dffre_reg;

    localparam int c_id_cnt   = 0;
    localparam int c_id_edge  = 1;
    localparam int c_id_pulse = 2;
    localparam int c_id_lat   = 3;
    localparam int c_id_pri   = 4;
    localparam int c_id_ign   = 5;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] exp;
    } sb_entry_t;

    logic clk;
    logic pre_chk = 1'b0;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    sb_entry_t sb[$];

    // Counter: WIDTH 8, no enable, d = q + 1
    logic       r_cnt, en_cnt;
    logic [7:0] q_cnt, d_cnt;
    // Edge detector: WIDTH 1, no enable
    logic       r_edge, en_edge, x, q_edge, w_pulse;
    // Enable latch: WIDTH 32, enable
    logic        r_lat, en_lat;
    logic [31:0] d_lat, q_lat;
    // Reset priority: WIDTH 16, RESET_VALUE A5A5, enable
    logic        r_pri, en_pri;
    logic [15:0] d_pri, q_pri;
    // Enable ignored: WIDTH 8, no enable
    logic       r_ign, en_ign;
    logic [7:0] d_ign, q_ign;

    assign d_cnt   = q_cnt + 8'd1;
    assign w_pulse = x & ~q_edge;

    dffre_reg #(.WIDTH(8), .USE_EN(1'b0)) u_cnt (
        .clk(clk), .r(r_cnt), .en(en_cnt), .d(d_cnt), .q(q_cnt));
    dffre_reg #(.WIDTH(1), .USE_EN(1'b0)) u_edge (
        .clk(clk), .r(r_edge), .en(en_edge), .d(x), .q(q_edge));
    dffre_reg #(.WIDTH(32), .USE_EN(1'b1)) u_lat (
        .clk(clk), .r(r_lat), .en(en_lat), .d(d_lat), .q(q_lat));
    dffre_reg #(.WIDTH(16), .RESET_VALUE(16'hA5A5), .USE_EN(1'b1)) u_pri (
        .clk(clk), .r(r_pri), .en(en_pri), .d(d_pri), .q(q_pri));
    dffre_reg #(.WIDTH(8), .USE_EN(1'b0)) u_ign (
        .clk(clk), .r(r_ign), .en(en_ign), .d(d_ign), .q(q_ign));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int id);
        case (id)
            c_id_cnt:   return {24'd0, q_cnt};
            c_id_edge:  return {31'd0, q_edge};
            c_id_pulse: return {31'd0, w_pulse};
            c_id_lat:   return q_lat;
            c_id_pri:   return {16'd0, q_pri};
            default:    return {24'd0, q_ign};
        endcase
    endfunction

    function automatic string id_name(input int id);
        case (id)
            c_id_cnt:   return "counter_q";
            c_id_edge:  return "edge_q";
            c_id_pulse: return "edge_pulse";
            c_id_lat:   return "enable_latch_q";
            c_id_pri:   return "reset_priority_q";
            default:    return "en_ignored_q";
        endcase
    endfunction

    // Expectation for the value seen dcyc rising edges from now (0 = before the next edge).
    task automatic push(input int id, input logic [31:0] exp, input int dcyc);
        sb_entry_t e;
        e.cyc = cyc + dcyc;
        e.id  = id;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: retire every expectation due in the current cycle.
    always @(negedge clk or posedge pre_chk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [31:0] act;
                act = actual(sb[i].id);
                n_checks++;
                if (sb[i].cyc != cyc || act !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got %h expected %h", id_name(sb[i].id),
                             sb[i].cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        logic [7:0] pat;
        logic       prev;
        pat = 8'b1001_0110;

        r_cnt  = 1'b0; en_cnt  = 1'b0;
        r_edge = 1'b0; en_edge = 1'b0; x = 1'b0;
        r_lat  = 1'b0; en_lat  = 1'b0; d_lat = 32'h0;
        r_pri  = 1'b1; en_pri  = 1'b0; d_pri = 16'h0;
        r_ign  = 1'b1; en_ign  = 1'b0; d_ign = 8'h3C;

        // Values held before any clock edge
        push(c_id_cnt, 32'h0, 0);
        push(c_id_edge, 32'h0, 0);
        push(c_id_lat, 32'h0, 0);
        push(c_id_pri, 32'h0000A5A5, 0);
        push(c_id_ign, 32'h0, 0);
        #2 pre_chk = 1'b1;

        // Counter reset for two edges, then free-run through the 255->0 wrap
        push(c_id_cnt, 32'h0, 1);
        push(c_id_cnt, 32'h0, 2);
        push(c_id_ign, 32'h3C, 1);
        push(c_id_edge, 32'h0, 1);
        push(c_id_lat, 32'h0, 1);
        push(c_id_pri, 32'h0000A5A5, 1);
        step();
        r_edge = 1'b1;
        r_lat  = 1'b1;
        step();
        r_cnt = 1'b1;
        for (int n = 1; n <= 258; n++) begin
            push(c_id_cnt, 32'(n % 256), n);
        end

        // Edge detect: q is x one edge late, pulse marks each rising x
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = pat[i];
            push(c_id_pulse, {31'd0, pat[i] & ~prev}, 0);
            push(c_id_edge, {31'd0, pat[i]}, 1);
            prev = pat[i];
            step();
        end

        // Enable latch: one load, then ten edges of hold with new d
        d_lat = 32'hDEADBEEF; en_lat = 1'b1;
        push(c_id_lat, 32'hDEADBEEF, 1);
        step();
        d_lat = 32'h12345678; en_lat = 1'b0;
        for (int k = 1; k <= 10; k++) push(c_id_lat, 32'hDEADBEEF, k);
        for (int k = 0; k < 10; k++) step();
        en_lat = 1'b1;
        push(c_id_lat, 32'h12345678, 1);
        step();

        // Reset beats enable, then a plain load on release
        r_pri = 1'b0; en_pri = 1'b1; d_pri = 16'hFFFF;
        push(c_id_pri, 32'h0000A5A5, 1);
        step();
        r_pri = 1'b1;
        push(c_id_pri, 32'h0000FFFF, 1);
        step();
        en_pri = 1'b0; d_pri = 16'h1234;
        push(c_id_pri, 32'h0000FFFF, 1);
        step();

        // Mid-cycle reset pulse and enable glitch must not reach q
        push(c_id_pri, 32'h0000FFFF, 0);
        push(c_id_pri, 32'h0000FFFF, 1);
        r_pri = 1'b0;
        #2 r_pri = 1'b1;
        step();
        push(c_id_pri, 32'h0000FFFF, 0);
        push(c_id_pri, 32'h0000FFFF, 1);
        en_pri = 1'b1; d_pri = 16'h0000;
        #2 en_pri = 1'b0;
        step();

        // Reset in mid-operation with enable low still loads RESET_VALUE
        r_pri = 1'b0;
        push(c_id_pri, 32'h0000A5A5, 1);
        step();
        r_pri = 1'b1;

        // Enable held low is ignored when USE_EN is 0
        d_ign = 8'hC3;
        push(c_id_ign, 32'h000000C3, 1);
        step();

        for (int t = 0; t < 400 && sb.size() != 0; t++) step();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
